vector_mac_engine: RTL and testbench

- Streaming signed dot-product (multiply-accumulate) engine behind the vector_acc AXI4-Lite register file.
- The register file supplies the start strobe and vector length, pushes operand pairs through a valid/ready stream, and pops the final accumulator value through a valid/ready result port.
- busy, done_irq and overflow feed the register file's status register.

---
 rtl/vector_mac_pkg.sv | 20 ++
 rtl/vector_mac_if.sv | 26 ++
 rtl/vector_mac_datapath.sv | 82 ++++++++
 rtl/vector_mac_engine.sv | 133 +++++++++++++
 tb/tb_vector_mac_engine.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_mac_pkg.sv
// Shared types and default widths for the vector_mac_engine dot-product slice.
// Default build wraps; define VMAC_SATURATE_EN for a saturating accumulator.
package vector_mac_pkg;

   localparam int VMAC_DATA_W = 16;
   localparam int VMAC_ACC_W  = 40;
   localparam int VMAC_LEN_W  = 16;
   localparam int VMAC_PROD_W = 2 * VMAC_DATA_W;

   localparam logic signed [VMAC_ACC_W-1:0] VMAC_SAT_MAX = {1'b0, {(VMAC_ACC_W-1){1'b1}}};
   localparam logic signed [VMAC_ACC_W-1:0] VMAC_SAT_MIN = {1'b1, {(VMAC_ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/vector_mac_if.sv
// Operand stream and result handshake between the register file (master)
// and the engine (slave).
interface vector_mac_if
   import vector_mac_pkg::*;
#(
   parameter int DATA_W = VMAC_DATA_W,
   parameter int ACC_W  = VMAC_ACC_W
);
   logic                     s_valid;
   logic                     s_ready;
   logic signed [DATA_W-1:0] s_a;
   logic signed [DATA_W-1:0] s_b;
   logic                     m_valid;
   logic                     m_ready;
   logic signed [ACC_W-1:0]  m_result;

   modport master (
      output s_valid, s_a, s_b, m_ready,
      input  s_ready, m_valid, m_result
   );

   modport slave (
      input  s_valid, s_a, s_b, m_ready,
      output s_ready, m_valid, m_result
   );
endinterface

// File: rtl/vector_mac_datapath.sv
// Two-stage multiply-accumulate pipeline with signed overflow detection.
// VMAC_SATURATE_EN selects clamping instead of modulo-2^ACC_W wrap.
module vector_mac_datapath
   import vector_mac_pkg::*;
#(
   parameter int DATA_W = VMAC_DATA_W,
   parameter int ACC_W  = VMAC_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic                     prod_valid,
   output logic                     acc_valid,
   output logic signed [ACC_W-1:0]  acc,
   output logic                     overflow
);
   localparam int PROD_W = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [PROD_W-1:0] prod_r;
   logic                     prod_valid_r;
   logic                     acc_valid_r;
   logic signed [ACC_W-1:0]  acc_r;
   logic                     overflow_r;
   logic signed [ACC_W-1:0]  prod_ext_s;
   logic signed [ACC_W-1:0]  sum_s;
   logic signed [ACC_W-1:0]  acc_next_s;
   logic                     ovf_s;

   // Sign-extended add, overflow when same-sign operands yield a different-sign sum
   always_comb begin
      prod_ext_s = ACC_W'(prod_r);
      sum_s      = acc_r + prod_ext_s;
      ovf_s      = (acc_r[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                   (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
`ifdef VMAC_SATURATE_EN
      if (ovf_s) begin
         acc_next_s = acc_r[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end else begin
         acc_next_s = sum_s;
      end
`else
      acc_next_s = sum_s;
`endif
   end

   // Product register, accumulator and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_r       <= {PROD_W{1'b0}};
         prod_valid_r <= 1'b0;
         acc_valid_r  <= 1'b0;
         acc_r        <= {ACC_W{1'b0}};
         overflow_r   <= 1'b0;
      end else begin
         prod_valid_r <= in_valid;
         acc_valid_r  <= prod_valid_r;
         if (in_valid) begin
            prod_r <= PROD_W'(a) * PROD_W'(b);
         end
         if (clear) begin
            acc_r      <= {ACC_W{1'b0}};
            overflow_r <= 1'b0;
         end else if (prod_valid_r) begin
            acc_r <= acc_next_s;
            if (ovf_s) begin
               overflow_r <= 1'b1;
            end
         end
      end
   end

   assign prod_valid = prod_valid_r;
   assign acc_valid  = acc_valid_r;
   assign acc        = acc_r;
   assign overflow   = overflow_r;

endmodule

// File: rtl/vector_mac_engine.sv
// Streaming signed dot-product engine: FSM, element counter and handshakes.
// Optional VMAC_SATURATE_EN (in the datapath) clamps instead of wrapping.
module vector_mac_engine
   import vector_mac_pkg::*;
#(
   parameter int DATA_W = VMAC_DATA_W,
   parameter int ACC_W  = VMAC_ACC_W,
   parameter int LEN_W  = VMAC_LEN_W
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             cfg_start,
   input  logic [LEN_W-1:0] cfg_len,
   vector_mac_if.slave      bus,
   output logic             busy,
   output logic             done_irq,
   output logic             overflow
);
   state_t                  state_r;
   state_t                  state_next_s;
   logic [LEN_W-1:0]        len_r;
   logic [LEN_W-1:0]        cnt_r;
   logic                    busy_r;
   logic                    m_valid_r;
   logic                    done_irq_r;
   logic                    start_ok_s;
   logic                    accept_s;
   logic                    last_s;
   logic                    pop_s;
   logic                    prod_valid_s;
   logic                    acc_valid_s;
   logic                    overflow_s;
   logic signed [ACC_W-1:0] acc_s;

   assign start_ok_s  = cfg_start && (state_r == IDLE);
   assign bus.s_ready = (state_r == RUN) && (cnt_r < len_r);
   assign accept_s    = bus.s_valid && bus.s_ready;
   assign last_s      = (cnt_r == (len_r - LEN_W'(1)));
   assign pop_s       = m_valid_r && bus.m_ready;

   // State register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (cfg_start) begin
               if (cfg_len != {LEN_W{1'b0}}) begin
                  state_next_s = RUN;
               end else begin
                  state_next_s = HOLD;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (accept_s && last_s) begin
               state_next_s = DRAIN;
            end else begin
               state_next_s = RUN;
            end
         end
         DRAIN: begin
            if (!prod_valid_s && !acc_valid_s) begin
               state_next_s = HOLD;
            end else begin
               state_next_s = DRAIN;
            end
         end
         HOLD: begin
            if (pop_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Length latch, accepted-pair counter and registered status outputs
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         len_r      <= {LEN_W{1'b0}};
         cnt_r      <= {LEN_W{1'b0}};
         busy_r     <= 1'b0;
         m_valid_r  <= 1'b0;
         done_irq_r <= 1'b0;
      end else begin
         if (start_ok_s) begin
            len_r <= cfg_len;
            cnt_r <= {LEN_W{1'b0}};
         end else if (accept_s) begin
            cnt_r <= cnt_r + LEN_W'(1);
         end
         busy_r     <= (state_next_s != IDLE);
         m_valid_r  <= (state_next_s == HOLD);
         done_irq_r <= pop_s;
      end
   end

   vector_mac_datapath #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_datapath (
      .clk        (ACLK),
      .rst_n      (ARESETN),
      .clear      (start_ok_s),
      .in_valid   (accept_s),
      .a          (bus.s_a),
      .b          (bus.s_b),
      .prod_valid (prod_valid_s),
      .acc_valid  (acc_valid_s),
      .acc        (acc_s),
      .overflow   (overflow_s)
   );

   assign bus.m_valid  = m_valid_r;
   assign bus.m_result = acc_s;
   assign busy         = busy_r;
   assign done_irq     = done_irq_r;
   assign overflow     = overflow_s;

endmodule

// File: tb/tb_vector_mac_engine.sv
// Directed scoreboard bench for vector_mac_engine (ACC_W=32); expectations
// follow VMAC_SATURATE_EN when the bench is built with it.
module tb_vector_mac_engine;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;
   localparam int LEN_W  = 16;
   localparam longint SAT_MAX = 64'sd2147483647;
   localparam longint SAT_MIN = -64'sd2147483648;

   logic             ACLK = 1'b0;
   logic             ARESETN;
   logic             cfg_start;
   logic [LEN_W-1:0] cfg_len;
   logic             busy;
   logic             done_irq;
   logic             overflow;

   vector_mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

   vector_mac_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .cfg_start (cfg_start),
      .cfg_len   (cfg_len),
      .bus       (bus),
      .busy      (busy),
      .done_irq  (done_irq),
      .overflow  (overflow)
   );

   always #5 ACLK = ~ACLK;

   int      errors = 0;
   int      checks = 0;
   int      va [0:7];
   int      vb [0:7];
   longint  sb_q [$];
   bit      exp_ovf;
   int      lat;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [63:0] res();
      logic signed [63:0] r;
      r = bus.m_result;
      return r;
   endfunction

   // Reference dot product over va/vb with ACC_W=32 wrap or clamp per step
   function automatic longint model_dot(input int n, output bit ovf);
      longint acc;
      longint s;
      acc = 0;
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         s = acc + longint'(va[i]) * longint'(vb[i]);
         if (s > SAT_MAX || s < SAT_MIN) begin
            ovf = 1'b1;
`ifdef VMAC_SATURATE_EN
            s = (s > SAT_MAX) ? SAT_MAX : SAT_MIN;
`else
            s = longint'(int'(s));
`endif
         end
         acc = s;
      end
      return acc;
   endfunction

   task automatic start_job(input int n);
      bit ovf;
      longint e;
      e = model_dot(n, ovf);
      sb_q.push_back(e);
      exp_ovf = ovf;
      cfg_len   = LEN_W'(n);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic stream(input int n, input bit toggle);
      int idx;
      int guard;
      bit hs;
      idx   = 0;
      guard = 0;
      while (idx < n && guard < 100) begin
         bus.s_valid = toggle ? ~guard[0] : 1'b1;
         bus.s_a     = 16'(va[idx]);
         bus.s_b     = 16'(vb[idx]);
         hs          = bus.s_valid && bus.s_ready;
         tick();
         guard++;
         if (hs) idx++;
      end
      bus.s_valid = 1'b0;
      check("accepted_pairs", idx, n);
   endtask

   task automatic wait_result(output int l);
      l = 0;
      while (bus.m_valid !== 1'b1 && l < 50) begin
         tick();
         l++;
      end
   endtask

   task automatic pop_result(input string tag, input bit start_on_pop);
      longint e;
      check({tag, "_mvalid"}, bus.m_valid, 1);
      e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'sh7fff_ffff_ffff_ffff;
      check({tag, "_result"}, res(), e);
      check({tag, "_overflow"}, overflow, exp_ovf);
      bus.m_ready = 1'b1;
      if (start_on_pop) begin
         cfg_start = 1'b1;
         cfg_len   = 16'd5;
      end
      tick();
      bus.m_ready = 1'b0;
      cfg_start   = 1'b0;
      check({tag, "_done_irq"}, done_irq, 1);
      check({tag, "_mvalid_drop"}, bus.m_valid, 0);
      check({tag, "_idle"}, busy, 0);
      tick();
      check({tag, "_done_irq_pulse"}, done_irq, 0);
      check({tag, "_still_idle"}, busy, 0);
   endtask

   initial begin
      ARESETN     = 1'b0;
      cfg_start   = 1'b0;
      cfg_len     = 16'd0;
      bus.s_valid = 1'b0;
      bus.s_a     = 16'sd0;
      bus.s_b     = 16'sd0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_sready", bus.s_ready, 0);
      check("rst_mvalid", bus.m_valid, 0);
      check("rst_result", res(), 0);
      check("rst_done_irq", done_irq, 0);
      check("rst_overflow", overflow, 0);
      ARESETN = 1'b1;
      tick();

      // Basic dot product with latency check
      va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
      vb[0] = 1; vb[1] = 1; vb[2] = 1; vb[3] = 1;
      start_job(4);
      check("basic_busy", busy, 1);
      check("basic_sready", bus.s_ready, 1);
      stream(4, 1'b0);
      check("basic_sready_drop", bus.s_ready, 0);
      wait_result(lat);
      check("basic_latency", lat, 3);
      pop_result("basic", 1'b0);

      // Signed operands, s_valid toggling every other cycle
      va[0] = -5; va[1] = 7;  va[2] = -32768;
      vb[0] = 3;  vb[1] = -2; vb[2] = 2;
      start_job(3);
      stream(3, 1'b1);
      bus.s_valid = 1'b1;
      check("signed_no_extra_ready", bus.s_ready, 0);
      tick();
      bus.s_valid = 1'b0;
      wait_result(lat);
      check("signed_expected_value", sb_q.size() != 0 ? sb_q[0] : 64'sd0, -64'sd65565);
      pop_result("signed", 1'b0);

      // Zero length, backpressure and ignored starts in HOLD
      start_job(0);
      check("zero_mvalid_next", bus.m_valid, 1);
      for (int i = 0; i < 10; i++) begin
         cfg_start = i[0];
         cfg_len   = 16'd3;
         tick();
         check("hold_mvalid", bus.m_valid, 1);
         check("hold_result", res(), 0);
         check("hold_sready", bus.s_ready, 0);
      end
      cfg_start = 1'b0;
      pop_result("zero", 1'b1);

      // Overflow: three products of 2^30 into a 32-bit accumulator
      va[0] = -32768; va[1] = -32768; va[2] = -32768;
      vb[0] = -32768; vb[1] = -32768; vb[2] = -32768;
      start_job(3);
      stream(3, 1'b0);
      wait_result(lat);
`ifdef VMAC_SATURATE_EN
      check("ovf_expected_value", sb_q.size() != 0 ? sb_q[0] : 64'sd0, 64'sd2147483647);
`else
      check("ovf_expected_value", sb_q.size() != 0 ? sb_q[0] : 64'sd0, -64'sd1073741824);
`endif
      check("ovf_flag", overflow, 1);
      pop_result("ovf", 1'b0);

      // Back-to-back: start in the cycle after done_irq clears state
      va[0] = 3; va[1] = 4;
      vb[0] = 5; vb[1] = 6;
      start_job(2);
      check("b2b_busy", busy, 1);
      check("b2b_overflow_clear", overflow, 0);
      check("b2b_acc_clear", res(), 0);
      stream(2, 1'b0);
      wait_result(lat);
      check("b2b_latency", lat, 3);
      pop_result("b2b", 1'b0);

      // Reset mid-job aborts with in-flight products
      for (int i = 0; i < 8; i++) begin
         va[i] = 100 + i;
         vb[i] = 7;
      end
      start_job(8);
      stream(3, 1'b0);
      ARESETN = 1'b0;
      #1;
      sb_q.delete();
      check("abort_busy", busy, 0);
      check("abort_sready", bus.s_ready, 0);
      check("abort_mvalid", bus.m_valid, 0);
      check("abort_result", res(), 0);
      check("abort_done_irq", done_irq, 0);
      check("abort_overflow", overflow, 0);
      tick();
      ARESETN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_no_resume", bus.m_valid | busy | done_irq, 0);
      end
      va[0] = 2; va[1] = 3;
      vb[0] = 4; vb[1] = 5;
      start_job(2);
      stream(2, 1'b0);
      wait_result(lat);
      check("after_reset_expected", sb_q.size() != 0 ? sb_q[0] : 64'sd0, 64'sd23);
      pop_result("after_reset", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
